// File: rtl/ccl_pkg.sv
// Shared types and helpers for the connected-component labeller.
package ccl_pkg;

  localparam int unsigned PIXEL_W = 24;
  localparam int unsigned LABEL_W = 8;
  localparam int unsigned CHAN_W  = 8;
  localparam int unsigned SUM_W   = 10;

  typedef logic [LABEL_W-1:0] label_t;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  localparam label_t BG_LABEL  = label_t'(0);
  localparam label_t LABEL_MAX = '1;

  // Brightness approximation (R + 2G + B) / 4; the 10-bit sum cannot overflow.
  function automatic logic [CHAN_W-1:0] luma(input rgb_t p);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(p.r) + SUM_W'({p.g, 1'b0}) + SUM_W'(p.b);
    return sum[SUM_W-1:2];
  endfunction

endpackage

// File: rtl/ccl_line_buffer.sv
// One row of labels: combinational read, synchronous write, shared address.
module ccl_line_buffer
  import ccl_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  label_t            wdata,
  output label_t            rdata
);

  label_t mem [DEPTH];

  assign rdata = mem[addr];

  // Store the label decided for this column; read returns the previous row's value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/ccl_labeler.sv
// Streaming single-pass 4-connected component labeller, one pixel per enabled clock.
module ccl_labeler
  import ccl_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 1024,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [PIXEL_W-1:0] data,
  output logic [PIXEL_W-1:0] out
);

  localparam int unsigned COL_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_WIDTH - 1);

  logic [COL_W-1:0] col;
  logic             first_row;
  label_t           next_label;
  label_t           left_label;

  logic             col0;
  logic             row0;
  logic             fg;
  logic             alloc;
  label_t           base_next;
  label_t           nb_l;
  label_t           nb_u;
  label_t           label_d;
  label_t           ram_rd;
  logic [COL_W-1:0] addr;

  ccl_line_buffer #(
    .DEPTH (MAX_WIDTH),
    .ADDR_W(COL_W)
  ) u_line_buffer (
    .clk  (clk),
    .we   (en & ~reset_n),
    .addr (addr),
    .wdata(label_d),
    .rdata(ram_rd)
  );

  // Binarise, resolve row/column context and pick this pixel's label.
  always_comb begin
    fg        = (32'(luma(rgb_t'(data))) >= THRESHOLD);
    col0      = hsync | vsync;
    // vsync restarts the frame; a row start other than the frame's first leaves row 0.
    if (vsync) begin
      row0 = 1'b1;
    end else if (hsync && (col != '0)) begin
      row0 = 1'b0;
    end else begin
      row0 = first_row;
    end
    base_next = vsync ? label_t'(1) : next_label;
    addr      = col0 ? '0 : col;
    nb_l      = col0 ? BG_LABEL : left_label;
    nb_u      = row0 ? BG_LABEL : ram_rd;
    alloc     = 1'b0;
    label_d   = BG_LABEL;
    if (fg) begin
      if ((nb_l == BG_LABEL) && (nb_u == BG_LABEL)) begin
        label_d = base_next;
        alloc   = 1'b1;
      end else if (nb_l == BG_LABEL) begin
        label_d = nb_u;
      end else if (nb_u == BG_LABEL) begin
        label_d = nb_l;
      end else begin
        label_d = (nb_l < nb_u) ? nb_l : nb_u;
      end
    end
  end

  // Counters, neighbour state and the registered label output.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      out        <= '0;
      col        <= '0;
      first_row  <= 1'b1;
      next_label <= label_t'(1);
      left_label <= BG_LABEL;
    end else if (en) begin
      out        <= PIXEL_W'(label_d);
      left_label <= label_d;
      first_row  <= row0;
      if (alloc && (base_next != LABEL_MAX)) begin
        next_label <= base_next + label_t'(1);
      end else begin
        next_label <= base_next;
      end
      if (col0) begin
        col <= COL_W'(1);
      end else if (col != COL_MAX) begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ccl_labeler.sv
// Directed self-checking bench for ccl_labeler.
module tb_ccl_labeler;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        hsync;
  logic        vsync;
  logic [23:0] data;
  logic [23:0] out;

  int checks;
  int errors;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  ccl_labeler #(
    .MAX_WIDTH(1024),
    .THRESHOLD(128)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .hsync  (hsync),
    .vsync  (vsync),
    .data   (data),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // Feed one accepted pixel and check the label registered on that edge.
  task automatic pix(input logic h, input logic v, input logic [23:0] d,
                     input logic [7:0] exp, input string tag);
    en    = 1'b1;
    hsync = h;
    vsync = v;
    data  = d;
    @(posedge clk);
    #1;
    check(tag, out, {16'h0, exp});
  endtask

  // One 8-pixel row: mask bit i = white at column i, exp byte i = label at column i.
  task automatic row8(input logic v, input logic [7:0] mask, input logic [63:0] exp,
                      input string name);
    for (int i = 0; i < 8; i++) begin
      pix(i == 0, v && (i == 0), mask[i] ? WHITE : BLACK, exp[i*8 +: 8],
          $sformatf("%s_c%0d", name, i));
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b1;
    en      = 1'b0;
    hsync   = 1'b0;
    vsync   = 1'b0;
    data    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 24'h0);
    reset_n = 1'b0;

    // All black, 4 rows of 8.
    for (int r = 0; r < 4; r++) begin
      row8(1'b0, 8'h00, 64'h0, $sformatf("black_r%0d", r));
    end

    // Single white pixel at row 0, column 3.
    row8(1'b1, 8'b0000_1000, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, "single_r0");
    row8(1'b0, 8'b0000_0000, 64'h0, "single_r1");

    // Two 2x2 blocks at columns 1-2 and 5-6.
    row8(1'b1, 8'b0110_0110, {8'd0, 8'd2, 8'd2, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0}, "blocks_r0");
    row8(1'b0, 8'b0110_0110, {8'd0, 8'd2, 8'd2, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0}, "blocks_r1");

    // U shape: column 4 of row 2 sees L=1, U=2 and takes the minimum.
    row8(1'b1, 8'b0001_0001, {8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd1}, "ushape_r0");
    row8(1'b0, 8'b0001_0001, {8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd1}, "ushape_r1");
    row8(1'b0, 8'b0001_1111, {8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, "ushape_r2");

    // Saturation: 300 isolated white pixels in one long row.
    for (int i = 0; i < 600; i++) begin
      int lbl;
      lbl = (i / 2) + 1;
      if (lbl > 255) lbl = 255;
      pix(i == 0, i == 0, (i % 2 == 0) ? WHITE : BLACK,
          (i % 2 == 0) ? 8'(lbl) : 8'd0, $sformatf("sat_c%0d", i));
    end
    pix(1'b0, 1'b1, WHITE, 8'd1, "sat_vsync_restart");

    // en low mid-row: labels 1,0,2,2 | stall | 0,3,0,4.
    pix(1'b1, 1'b1, WHITE, 8'd1, "stall_c0");
    pix(1'b0, 1'b0, BLACK, 8'd0, "stall_c1");
    pix(1'b0, 1'b0, WHITE, 8'd2, "stall_c2");
    pix(1'b0, 1'b0, WHITE, 8'd2, "stall_c3");
    for (int k = 0; k < 3; k++) begin
      en    = 1'b0;
      hsync = 1'(k);
      vsync = 1'b1;
      data  = 24'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("stall_hold%0d", k), out, 24'd2);
    end
    pix(1'b0, 1'b0, BLACK, 8'd0, "stall_c4");
    pix(1'b0, 1'b0, WHITE, 8'd3, "stall_c5");
    pix(1'b0, 1'b0, BLACK, 8'd0, "stall_c6");
    pix(1'b0, 1'b0, WHITE, 8'd4, "stall_c7");

    // Threshold edges, including the doubled green weight.
    pix(1'b1, 1'b1, 24'h808080, 8'd1, "thr_808080");
    pix(1'b0, 1'b0, 24'h7F7F7F, 8'd0, "thr_7F7F7F");
    pix(1'b0, 1'b0, 24'h7F7F7F, 8'd0, "thr_7F7F7F_b");
    pix(1'b0, 1'b0, 24'h808080, 8'd2, "thr_808080_b");
    pix(1'b0, 1'b0, 24'h00FF00, 8'd0, "thr_00FF00");
    pix(1'b0, 1'b0, 24'h01FF01, 8'd3, "thr_01FF01");

    // Reset mid-frame; next pixel is row 0 column 0 without any sync.
    pix(1'b0, 1'b0, WHITE, 8'd3, "mid_pre");
    reset_n = 1'b1;
    data    = WHITE;
    @(posedge clk);
    #1;
    check("mid_reset_out", out, 24'h0);
    reset_n = 1'b0;
    pix(1'b0, 1'b0, WHITE, 8'd1, "mid_c0");
    pix(1'b0, 1'b0, BLACK, 8'd0, "mid_c1");
    pix(1'b0, 1'b0, WHITE, 8'd2, "mid_c2");
    pix(1'b1, 1'b0, WHITE, 8'd1, "mid_r1_c0");
    pix(1'b0, 1'b0, BLACK, 8'd0, "mid_r1_c1");
    pix(1'b0, 1'b0, WHITE, 8'd2, "mid_r1_c2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
